// File: rtl/cla_pkg.sv
// Shared types and constants for the pipelined carry-lookahead adder/subtractor.
package cla_pkg;

  localparam int GRP = 4;

  typedef logic [1:0] op_t;

  localparam op_t OP_ADD = 2'b00;
  localparam op_t OP_ADC = 2'b01;
  localparam op_t OP_SUB = 2'b10;
  localparam op_t OP_SBB = 2'b11;

  // Carry into bit 0: SUB supplies the +1 of two's complement, ADC/SBB take the external carry.
  function automatic logic carry_in(input op_t op, input logic cin);
    logic c;
    case (op)
      OP_ADD:         c = 1'b0;
      OP_SUB:         c = 1'b1;
      OP_ADC, OP_SBB: c = cin;
      default:        c = cin;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/cla_grp4_pg.sv
// 4-bit lookahead group: bit sums from an incoming carry, plus group propagate/generate.
module cla_grp4_pg (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       p,
  output logic       g
);

  logic [3:0] pi;
  logic [3:0] gi;
  logic [3:0] c;

  assign pi = a ^ b;
  assign gi = a & b;

  assign c[0] = cin;
  assign c[1] = gi[0] | (pi[0] & cin);
  assign c[2] = gi[1] | (pi[1] & gi[0]) | (pi[1] & pi[0] & cin);
  assign c[3] = gi[2] | (pi[2] & gi[1]) | (pi[2] & pi[1] & gi[0]) | (pi[2] & pi[1] & pi[0] & cin);

  assign s = pi ^ c;
  assign p = &pi;
  assign g = gi[3] | (pi[3] & gi[2]) | (pi[3] & pi[2] & gi[1]) | (pi[3] & pi[2] & pi[1] & gi[0]);

endmodule

// File: rtl/cla_pipe_addsub.sv
// Two-stage pipelined carry-lookahead add/subtract with valid/ready on both sides.
module cla_pipe_addsub
  import cla_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  op_t              op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int NG = WIDTH / GRP;

  logic [WIDTH-1:0] b_eff, s1_unused, s1_a, s1_b, sum2;
  logic [NG-1:0]    gp, gg, p2_unused, g2_unused;
  logic [NG:0]      gc, s1_c;
  logic [2:0]       tx, ty;
  logic             c0, c_msb, la_acc, la_prop;
  logic             s1_valid, s1_cmsb, s2_valid, adv1, adv2;

  assign b_eff = op[1] ? ~b : b;
  assign c0    = carry_in(op, cin);

  for (genvar k = 0; k < NG; k++) begin : g_s1
    cla_grp4_pg u_pg (
      .a  (a[GRP*k +: GRP]),
      .b  (b_eff[GRP*k +: GRP]),
      .cin(1'b0),
      .s  (s1_unused[GRP*k +: GRP]),
      .p  (gp[k]),
      .g  (gg[k])
    );
  end

  // Each group carry is a flat sum-of-products over all lower groups, so no carry ripples.
  always_comb begin
    gc      = '0;
    gc[0]   = c0;
    la_acc  = 1'b0;
    la_prop = 1'b1;
    for (int k = 0; k < NG; k++) begin
      la_acc  = 1'b0;
      la_prop = 1'b1;
      for (int j = k; j >= 0; j--) begin
        la_acc  = la_acc | (la_prop & gg[j]);
        la_prop = la_prop & gp[j];
      end
      gc[k+1] = la_acc | (la_prop & c0);
    end
  end

  assign tx    = a[WIDTH-2 -: 3] ^ b_eff[WIDTH-2 -: 3];
  assign ty    = a[WIDTH-2 -: 3] & b_eff[WIDTH-2 -: 3];
  assign c_msb = ty[2] | (tx[2] & ty[1]) | (tx[2] & tx[1] & ty[0]) | (tx[2] & tx[1] & tx[0] & gc[NG-1]);

  assign adv2      = ~s2_valid | out_ready;
  assign adv1      = ~s1_valid | adv2;
  assign in_ready  = adv1;
  assign out_valid = s2_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_c     <= '0;
      s1_cmsb  <= 1'b0;
    end else if (adv1) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a    <= a;
        s1_b    <= b_eff;
        s1_c    <= gc;
        s1_cmsb <= c_msb;
      end
    end
  end

  for (genvar k = 0; k < NG; k++) begin : g_s2
    cla_grp4_pg u_sum (
      .a  (s1_a[GRP*k +: GRP]),
      .b  (s1_b[GRP*k +: GRP]),
      .cin(s1_c[k]),
      .s  (sum2[GRP*k +: GRP]),
      .p  (p2_unused[k]),
      .g  (g2_unused[k])
    );
  end

  // Output register only loads on a real beat, so a stalled result stays put.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      ovf      <= 1'b0;
      zero     <= 1'b0;
      neg      <= 1'b0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        sum  <= sum2;
        cout <= s1_c[NG];
        ovf  <= s1_cmsb ^ s1_c[NG];
        zero <= (sum2 == '0);
        neg  <= sum2[WIDTH-1];
      end
    end
  end

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Scoreboard bench: three widths share one stimulus stream; expectations come from a+b_eff+c0.
module tb_cla_pipe_addsub;
  import cla_pkg::*;

  typedef struct packed {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic        neg;
  } exp_t;

  logic        clk, rst, inValid, readyDir, readyRand, randReady, outReady, cinDrv;
  logic [63:0] aDrv, bDrv;
  op_t         opDrv;
  logic        drvDirected, timedOut;
  exp_t        drvExp;
  int          testCount = 0;
  int          failCount = 0;
  exp_t        q4[$], q16[$], q64[$];

  logic        inReady4, outValid4, cout4, ovf4, zero4, neg4;
  logic [3:0]  sum4;
  logic        inReady16, outValid16, cout16, ovf16, zero16, neg16;
  logic [15:0] sum16;
  logic        inReady64, outValid64, cout64, ovf64, zero64, neg64;
  logic [63:0] sum64;

  assign outReady = randReady ? readyRand : readyDir;

  cla_pipe_addsub #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady4),
    .a(aDrv[3:0]), .b(bDrv[3:0]), .cin(cinDrv), .op(opDrv),
    .out_valid(outValid4), .out_ready(outReady), .sum(sum4),
    .cout(cout4), .ovf(ovf4), .zero(zero4), .neg(neg4)
  );

  cla_pipe_addsub #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady16),
    .a(aDrv[15:0]), .b(bDrv[15:0]), .cin(cinDrv), .op(opDrv),
    .out_valid(outValid16), .out_ready(outReady), .sum(sum16),
    .cout(cout16), .ovf(ovf16), .zero(zero16), .neg(neg16)
  );

  cla_pipe_addsub #(.WIDTH(64)) dut64 (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady64),
    .a(aDrv), .b(bDrv), .cin(cinDrv), .op(opDrv),
    .out_valid(outValid64), .out_ready(outReady), .sum(sum64),
    .cout(cout64), .ovf(ovf64), .zero(zero64), .neg(neg64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    readyRand = ($urandom_range(0, 3) != 0);
  end

  function automatic exp_t mkExp(input logic [63:0] s, input logic c, input logic o, input logic z, input logic n);
    exp_t r;
    r.sum = s; r.cout = c; r.ovf = o; r.zero = z; r.neg = n;
    return r;
  endfunction

  // Plain wide-integer reference: sign rule for overflow, bit w of the full sum for carry out.
  function automatic exp_t model(input int w, input logic [63:0] av, input logic [63:0] bv, input logic [1:0] opv, input logic cv);
    logic [64:0] full;
    logic [63:0] mask, ae, be;
    logic        c0;
    exp_t        r;
    mask   = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    ae     = av & mask;
    be     = (opv[1] ? ~bv : bv) & mask;
    c0     = (opv == 2'b00) ? 1'b0 : (opv == 2'b10) ? 1'b1 : cv;
    full   = {1'b0, ae} + {1'b0, be} + {64'd0, c0};
    r.sum  = full[63:0] & mask;
    r.cout = full[w];
    r.neg  = r.sum[w-1];
    r.zero = (r.sum == 64'd0);
    r.ovf  = (ae[w-1] == be[w-1]) && (r.neg != ae[w-1]);
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic checkBeat(input string tag, input exp_t act, input exp_t e);
    checkOutput({tag, ".sum"},  act.sum,  e.sum);
    checkOutput({tag, ".cout"}, act.cout, e.cout);
    checkOutput({tag, ".ovf"},  act.ovf,  e.ovf);
    checkOutput({tag, ".zero"}, act.zero, e.zero);
    checkOutput({tag, ".neg"},  act.neg,  e.neg);
  endtask

  // Pop-and-compare on each output transfer, peek while stalled, then push newly accepted beats.
  always @(negedge clk) begin
    if (!rst) begin
      if (outValid4 && outReady) begin
        if (q4.size() == 0) checkOutput("extra_beat4", 1, 0);
        else checkBeat("w4", mkExp(64'(sum4), cout4, ovf4, zero4, neg4), q4.pop_front());
      end else if (outValid4 && q4.size() > 0)
        checkBeat("stall4", mkExp(64'(sum4), cout4, ovf4, zero4, neg4), q4[0]);
      if (outValid16 && outReady) begin
        if (q16.size() == 0) checkOutput("extra_beat16", 1, 0);
        else checkBeat("w16", mkExp(64'(sum16), cout16, ovf16, zero16, neg16), q16.pop_front());
      end else if (outValid16 && q16.size() > 0)
        checkBeat("stall16", mkExp(64'(sum16), cout16, ovf16, zero16, neg16), q16[0]);
      if (outValid64 && outReady) begin
        if (q64.size() == 0) checkOutput("extra_beat64", 1, 0);
        else checkBeat("w64", mkExp(sum64, cout64, ovf64, zero64, neg64), q64.pop_front());
      end else if (outValid64 && q64.size() > 0)
        checkBeat("stall64", mkExp(sum64, cout64, ovf64, zero64, neg64), q64[0]);
      if (inValid && inReady4)  q4.push_back(model(4, aDrv, bDrv, opDrv, cinDrv));
      if (inValid && inReady16) q16.push_back(drvDirected ? drvExp : model(16, aDrv, bDrv, opDrv, cinDrv));
      if (inValid && inReady64) q64.push_back(model(64, aDrv, bDrv, opDrv, cinDrv));
    end
  end

  task automatic applyStimulus(input logic [63:0] av, input logic [63:0] bv, input op_t opv, input logic cv,
                               input logic dir, input exp_t e);
    logic acc;
    int   n;
    aDrv = av; bDrv = bv; opDrv = opv; cinDrv = cv;
    drvDirected = dir; drvExp = e; inValid = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 20) begin
      @(negedge clk);
      acc = inReady16;
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("accept", acc, 1);
    if (!acc) timedOut = 1'b1;
    inValid = 1'b0;
  endtask

  function automatic logic [63:0] pickOperand();
    case ($urandom_range(0, 7))
      0:       return 64'd0;
      1:       return {64{1'b1}};
      2:       return 64'd1;
      3:       return 64'h7777_7777_7777_7777;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int stale, n;
    rst = 1'b1; inValid = 1'b0; readyDir = 1'b1; randReady = 1'b0; readyRand = 1'b0;
    aDrv = '0; bDrv = '0; opDrv = OP_ADD; cinDrv = 1'b0;
    drvDirected = 1'b0; drvExp = '0; timedOut = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_out_valid", outValid16, 0);
    checkOutput("rst_sum", sum16, 0);
    checkOutput("rst_flags", {cout16, ovf16, zero16, neg16}, 0);
    checkOutput("rst_in_ready", inReady16, 1);
    @(posedge clk);
    #1;

    applyStimulus(64'h1234, 64'h4321, OP_ADD, 1'b0, 1'b1, mkExp(64'h5555, 0, 0, 0, 0));
    @(negedge clk);
    checkOutput("latency_1edge", outValid16, 0);
    @(negedge clk);
    checkOutput("latency_2edge", outValid16, 1);
    @(posedge clk);
    #1;
    applyStimulus(64'h0005, 64'h0007, OP_SUB, 1'b0, 1'b1, mkExp(64'hFFFE, 0, 0, 0, 1));
    applyStimulus(64'h7FFF, 64'h0001, OP_ADD, 1'b0, 1'b1, mkExp(64'h8000, 0, 1, 0, 1));
    applyStimulus(64'hFFFF, 64'h0001, OP_ADD, 1'b0, 1'b1, mkExp(64'h0000, 1, 0, 1, 0));
    applyStimulus(64'hFFFF, 64'h0000, OP_ADC, 1'b1, 1'b1, mkExp(64'h0000, 1, 0, 1, 0));
    applyStimulus(64'h0010, 64'h0001, OP_SBB, 1'b0, 1'b1, mkExp(64'h000E, 1, 0, 0, 0));
    repeat (4) @(posedge clk);
    #1;

    readyDir = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++)
          applyStimulus(64'h1111 * (i + 1), 64'h0101, OP_ADD, 1'b0, 1'b0, '0);
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("bp_in_ready", inReady16, 0);
        checkOutput("bp_out_valid", outValid16, 1);
        @(posedge clk);
        #1;
        readyDir = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    #1;

    readyDir = 1'b0;
    applyStimulus(64'h1234, 64'h1111, OP_ADD, 1'b0, 1'b0, '0);
    applyStimulus(64'h0F0F, 64'h0101, OP_SUB, 1'b0, 1'b0, '0);
    @(negedge clk);
    checkOutput("full_in_ready", inReady16, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q4.delete(); q16.delete(); q64.delete();
    @(negedge clk);
    checkOutput("midrst_out_valid", outValid16, 0);
    checkOutput("midrst_sum", sum16, 0);
    checkOutput("midrst_flags", {cout16, ovf16, zero16, neg16}, 0);
    checkOutput("midrst_in_ready", inReady16, 1);
    readyDir = 1'b1;
    stale = 0;
    repeat (10) begin
      @(negedge clk);
      if (outValid16 || outValid4 || outValid64) stale++;
    end
    checkOutput("no_stale", stale, 0);
    @(posedge clk);
    #1;

    randReady = 1'b1;
    for (int i = 0; i < 10000 && !timedOut; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      applyStimulus(pickOperand(), pickOperand(), op_t'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0, '0);
    end

    randReady = 1'b0;
    readyDir = 1'b1;
    n = 0;
    while ((q4.size() + q16.size() + q64.size()) != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    checkOutput("drain", q4.size() + q16.size() + q64.size(), 0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
